datapath_ctrl: RTL
==================

Name: datapath_ctrl

Overview:
- Multi-cycle controller FSM that sits directly upstream of the Lab 5 register file and datapath.
- Accepts one 16-bit instruction per valid/ready handshake and latches it.
- Sequences the register-file read/write selects, the pipeline-register loads, the ALU/shifter controls and the writeback mux select.
- Signals completion with a one-cycle done pulse; flags unsupported encodings with err.

Parameters:
- DATA_W, 16, datapath width; width of sximm8.
- IMM_W, 8, immediate field width, sign-extended to DATA_W.
- REG_ADDR_W, 3, register index width (8 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  high only in IDLE with rst_n high; accept = in_valid & in_ready.
- instr  in  16  instruction word, fields as in Behaviour.
- readnum  out  REG_ADDR_W  register-file read index.
- writenum  out  REG_ADDR_W  register-file write index.
- write  out  1  register-file write enable.
- loada, loadb, loadc, loads  out  1 each  load enables for A, B, C and status.
- asel, bsel  out  1 each  asel=1 forces the ALU A input to 0; bsel=1 selects sximm8 on the B side.
- vsel  out  2  writeback select: 00 = C, 10 = sximm8.
- shift  out  2  shifter op (from sh field).
- alu_op  out  2  ALU op (from op field).
- sximm8  out  DATA_W  sign-extended imm8 of the latched instruction.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the encoding is illegal.

Behaviour:
- Instruction fields: opcode=[15:13], op=[12:11], Rn=[10:8], Rd=[7:5], sh=[4:3], Rm=[2:0], imm8=[7:0].
- Reset (async, rst_n low): state goes to IDLE; latched instruction register (ir) = 0; every output = 0, including in_ready, sximm8, done and err. Reset mid-instruction aborts it with no further write.
- On accept, ir <= instr. Outside IDLE, instr and in_valid are ignored.
- In every state, outputs not listed for that state are 0. sximm8 is driven from ir continuously.
- States: IDLE, DECODE, LOAD_A, LOAD_B, EXEC, WRITE_C, WRITE_IMM, DONE.
- DECODE: no controls asserted; selects the path below.
- MOV Rn,#imm8 (110,10): DECODE -> WRITE_IMM (writenum=Rn, vsel=10, write=1) -> DONE.
- MOV Rd,Rm{,sh} (110,00): DECODE -> LOAD_B -> EXEC with asel=1 -> WRITE_C.
- ADD (101,00) and AND (101,10): DECODE -> LOAD_A -> LOAD_B -> EXEC -> WRITE_C.
- CMP (101,01): DECODE -> LOAD_A -> LOAD_B -> EXEC with loads=1 and loadc=0 -> DONE. No write.
- MVN (101,11): DECODE -> LOAD_B -> EXEC -> WRITE_C. LOAD_A is skipped.
- LOAD_A: readnum=Rn, loada=1.
- LOAD_B: readnum=Rm, loadb=1.
- EXEC: shift=sh, alu_op=op (00 for MOV), bsel=0, loadc=1 (except CMP).
- WRITE_C: writenum=Rd, vsel=00, write=1 -> DONE.
- Any other opcode/op combination: DECODE -> DONE with err=1. No register-file control is asserted.
- DONE: done=1 for exactly one cycle -> IDLE. in_ready returns high the following cycle.
- Latency, counted in cycles after the accept edge, done asserted in cycle N:
  - MOV imm: N=3.
  - MOV reg / MVN: N=5.
  - CMP: N=5.
  - ADD/AND: N=6.
  - illegal: N=2.
- Back-to-back: in_valid held high gives the next accept in the cycle after DONE.

Optional Feature:
- Macro: DATAPATH_CTRL_FASTMOV_EN.
- Defined: an accepted MOV-immediate goes IDLE -> WRITE_IMM directly, skipping DECODE, so done comes at N=2. All other paths are unchanged.
- Undefined: MOV-immediate passes through DECODE as specified above (N=3).

Decomposition:
- Package datapath_ctrl_pkg holds:
  - opcode/op localparams (OPC_MOV=110, OPC_ALU=101, OP_ADD..OP_MVN);
  - state encoding;
  - VSEL_C=00, VSEL_IMM=10;
  - instruction field bit positions.
- Sub-module datapath_ctrl_decode: combinational field extraction, sign extension and legality check on ir. The FSM stays in datapath_ctrl.

Test Plan:
- Reset, then instr=0xD0FD (MOV R0,#-3) with in_valid -> cycle 2 write=1, writenum=0, vsel=10, sximm8=0xFFFD; cycle 3 done=1, err=0. With FASTMOV_EN, each of these events comes one cycle earlier.
- instr=0xA148 (ADD R2,R1,R0,LSL) -> cycles 2-5:
  - cycle 2: readnum=1, loada=1;
  - cycle 3: readnum=0, loadb=1;
  - cycle 4: loadc=1, shift=01, alu_op=00;
  - cycle 5: write=1, writenum=2, vsel=00;
  - cycle 6: done=1.
- instr=0xA900 (CMP R1,R0) -> cycle 4 loads=1, loadc=0; write stays 0 throughout; done at cycle 5.
- instr=0xB861 (MVN R3,R1) -> loada never asserted; cycle 2 readnum=1, loadb=1; cycle 4 write=1, writenum=3; done at cycle 5.
- instr=0x0000 (illegal) -> cycle 2 done=1, err=1; no write/load ever asserted; in_ready=1 at cycle 3. Changing instr while busy has no effect.
- Start 0xA148, drive rst_n=0 during EXEC -> all outputs 0 immediately. After release: in_ready=1, state IDLE, no write seen.

Source files
------------

// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared encodings for the datapath controller
// Purpose: opcode/op codes, writeback selects, instruction field positions,
//          FSM state encoding and the instruction classifier.
// Ports:   none (package).
package datapath_ctrl_pkg;

  localparam int INSTR_W = 16;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int OP_MSB  = 12;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_MSB  = 4;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WRITE_C, S_WRITE_IMM, S_DONE
  } state_e;

  // Path class of an instruction; selects the FSM route out of DECODE.
  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_MOV_IMM, CLS_MOV_REG, CLS_ALU, CLS_CMP, CLS_MVN
  } instr_cls_e;

  function automatic instr_cls_e classify(input logic [INSTR_W-1:0] w);
    logic [2:0] opc;
    logic [1:0] op;
    instr_cls_e c;
    opc = w[OPC_MSB:OPC_LSB];
    op  = w[OP_MSB:OP_LSB];
    c   = CLS_ILLEGAL;
    if (opc == OPC_MOV && op == OP_MOV_IMM)      c = CLS_MOV_IMM;
    else if (opc == OPC_MOV && op == OP_MOV_REG) c = CLS_MOV_REG;
    else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD, OP_AND: c = CLS_ALU;
        OP_CMP:         c = CLS_CMP;
        OP_MVN:         c = CLS_MVN;
        default:        c = CLS_ILLEGAL;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction handshake and datapath control bundle
// Purpose: groups the instruction input handshake and all register-file /
//          datapath control outputs of the controller.
// Ports:   master = instruction source / datapath side (drives in_valid, instr)
//          slave  = controller (drives in_ready and all controls)
interface datapath_ctrl_if #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [datapath_ctrl_pkg::INSTR_W-1:0] instr;
  logic [REG_ADDR_W-1:0]                readnum;
  logic [REG_ADDR_W-1:0]                writenum;
  logic                                 write;
  logic                                 loada;
  logic                                 loadb;
  logic                                 loadc;
  logic                                 loads;
  logic                                 asel;
  logic                                 bsel;
  logic [1:0]                           vsel;
  logic [1:0]                           shift;
  logic [1:0]                           alu_op;
  logic [DATA_W-1:0]                    sximm8;
  logic                                 done;
  logic                                 err;

  modport master (
    output in_valid, instr,
    input  in_ready, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, sximm8, done, err
  );

  modport slave (
    input  in_valid, instr,
    output in_ready, readnum, writenum, write, loada, loadb, loadc, loads,
           asel, bsel, vsel, shift, alu_op, sximm8, done, err
  );
endinterface

// File: rtl/datapath_ctrl_decode.sv
// rtl/datapath_ctrl_decode.sv - field extraction and classification of ir
// Purpose: purely combinational split of the latched instruction into its
//          register/shift/op fields, sign-extended imm8 and path class.
// Ports:   ir (in)                      latched instruction
//          rn, rd, rm (out)             register indices
//          op, sh (out)                 ALU op and shifter op fields
//          sximm8 (out)                 imm8 sign-extended to DATA_W
//          cls (out)                    path class, CLS_ILLEGAL if unsupported
module datapath_ctrl_decode
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic [INSTR_W-1:0]    ir,
  output logic [REG_ADDR_W-1:0] rn,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rm,
  output logic [1:0]            op,
  output logic [1:0]            sh,
  output logic [DATA_W-1:0]     sximm8,
  output instr_cls_e            cls
);

  assign rn     = ir[RN_LSB +: REG_ADDR_W];
  assign rd     = ir[RD_LSB +: REG_ADDR_W];
  assign rm     = ir[RM_LSB +: REG_ADDR_W];
  assign op     = ir[OP_MSB:OP_LSB];
  assign sh     = ir[SH_MSB:SH_LSB];
  assign sximm8 = {{(DATA_W-IMM_W){ir[IMM_LSB+IMM_W-1]}}, ir[IMM_LSB +: IMM_W]};
  assign cls    = classify(ir);

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - multi-cycle controller for the register file/datapath
// Purpose: accepts one instruction per handshake, latches it and sequences the
//          register-file, pipeline-register, ALU/shifter and writeback
//          controls, ending each instruction with a one-cycle done pulse.
// Ports:   clk, rst_n (async active-low); dp (slave modport): in_valid/in_ready/
//          instr handshake, readnum, writenum, write, loada..loads, asel, bsel,
//          vsel, shift, alu_op, sximm8, done, err.
// Option:  DATAPATH_CTRL_FASTMOV_EN - MOV-immediate skips DECODE (done one
//          cycle earlier).
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMM_W      = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  datapath_ctrl_if.slave   dp
);

  state_e                state, state_nxt;
  logic [INSTR_W-1:0]    ir;
  logic [REG_ADDR_W-1:0] rn, rd, rm;
  logic [1:0]            op, sh;
  logic [DATA_W-1:0]     sximm8;
  instr_cls_e            cls;
  logic                  accept;

  datapath_ctrl_decode #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .REG_ADDR_W(REG_ADDR_W)
  ) u_decode (
    .ir(ir), .rn(rn), .rd(rd), .rm(rm), .op(op), .sh(sh),
    .sximm8(sximm8), .cls(cls)
  );

  // Gated with rst_n so in_ready is low for the whole reset, not just after it.
  assign dp.in_ready = (state == S_IDLE) & rst_n;
  assign accept      = dp.in_valid & dp.in_ready;
  assign dp.sximm8   = sximm8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ir <= dp.instr;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef DATAPATH_CTRL_FASTMOV_EN
          // ir is not loaded yet, so classify the incoming word directly.
          state_nxt = (classify(dp.instr) == CLS_MOV_IMM) ? S_WRITE_IMM : S_DECODE;
`else
          state_nxt = S_DECODE;
`endif
        end
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:          state_nxt = S_WRITE_IMM;
          CLS_MOV_REG, CLS_MVN: state_nxt = S_LOAD_B;
          CLS_ALU, CLS_CMP:     state_nxt = S_LOAD_A;
          default:              state_nxt = S_DONE;
        endcase
      end
      S_LOAD_A:    state_nxt = S_LOAD_B;
      S_LOAD_B:    state_nxt = S_EXEC;
      S_EXEC:      state_nxt = (cls == CLS_CMP) ? S_DONE : S_WRITE_C;
      S_WRITE_C:   state_nxt = S_DONE;
      S_WRITE_IMM: state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dp.readnum  = '0;
    dp.writenum = '0;
    dp.write    = 1'b0;
    dp.loada    = 1'b0;
    dp.loadb    = 1'b0;
    dp.loadc    = 1'b0;
    dp.loads    = 1'b0;
    dp.asel     = 1'b0;
    dp.bsel     = 1'b0;
    dp.vsel     = VSEL_C;
    dp.shift    = 2'b00;
    dp.alu_op   = 2'b00;
    dp.done     = 1'b0;
    dp.err      = 1'b0;
    case (state)
      S_LOAD_A: begin
        dp.readnum = rn;
        dp.loada   = 1'b1;
      end
      S_LOAD_B: begin
        dp.readnum = rm;
        dp.loadb   = 1'b1;
      end
      S_EXEC: begin
        dp.shift  = sh;
        // MOV reg passes B through: A forced to 0 and the ALU told to add.
        dp.alu_op = (cls == CLS_MOV_REG) ? 2'b00 : op;
        dp.asel   = (cls == CLS_MOV_REG);
        dp.loadc  = (cls != CLS_CMP);
        dp.loads  = (cls == CLS_CMP);
      end
      S_WRITE_C: begin
        dp.writenum = rd;
        dp.vsel     = VSEL_C;
        dp.write    = 1'b1;
      end
      S_WRITE_IMM: begin
        dp.writenum = rn;
        dp.vsel     = VSEL_IMM;
        dp.write    = 1'b1;
      end
      S_DONE: begin
        dp.done = 1'b1;
        dp.err  = (cls == CLS_ILLEGAL);
      end
      default: ;
    endcase
  end

endmodule
